// File: rtl/add_sub_serial_pkg.sv
// Shared types for the key-locked serial add/subtract unit: state encoding and
// the decoy-ring successor function.
package add_sub_serial_pkg;

  localparam int unsigned StateW = 5;

  // Decoy k is encoded as StDecoy0 + k, so the ring can grow up to 29 states.
  typedef enum logic [StateW-1:0] {
    StIdle   = 5'd0,
    StAdd    = 5'd1,
    StDone   = 5'd2,
    StDecoy0 = 5'd3
  } state_t;

  function automatic state_t decoy_next(state_t cur, int unsigned num_decoy);
    logic [StateW-1:0] idx;
    idx = cur - StDecoy0;
    if (32'(idx) + 32'd1 >= num_decoy) idx = '0;
    else idx = idx + 5'd1;
    return state_t'(idx + StDecoy0);
  endfunction

endpackage

// File: rtl/add_sub_serial_locked_if.sv
// Request/result bundle of the serial add/subtract unit.
interface add_sub_serial_locked_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (output start, sub, a, b, input out, cout, ovf, busy, done);
  modport slave  (input start, sub, a, b, output out, cout, ovf, busy, done);
endinterface

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit adder with carry-in and carry-out.
module serial_digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  end
endmodule

// File: rtl/add_sub_serial_locked.sv
// Key-locked WIDTH-bit serial add/subtract, DIGIT bits per cycle; a wrong key
// at start sends control into a decoy ring that never returns a result.
module add_sub_serial_locked
  import add_sub_serial_pkg::*;
#(
  parameter int unsigned          WIDTH     = 16,
  parameter int unsigned          DIGIT     = 1,
  parameter int unsigned          NUM_DECOY = 4,
  parameter int unsigned          KEY_WIDTH = 8,
  parameter logic [KEY_WIDTH-1:0] KEY_VALUE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] key,
  add_sub_serial_locked_if.slave bus
);
  localparam int unsigned NumDigits = WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, out_q, out_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              key_ok;
  logic [DIGIT-1:0]  dsum;
  logic              dcarry;

  serial_digit_adder #(.DIGIT(DIGIT)) u_adder (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcarry)
  );

  assign key_ok = (key == KEY_VALUE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (key_ok) begin
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub;
            count_d = '0;
            out_d   = '0;
            sa_d    = bus.a[WIDTH-1];
            sb_d    = b_d[WIDTH-1];
            state_d = StAdd;
          end else begin
            state_d = StDecoy0;
          end
        end
      end
      StAdd: begin
        out_d   = {dsum, out_q[WIDTH-1:DIGIT]};
        carry_d = dcarry;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(NumDigits - 1)) begin
          // Flags use the final digit so they are valid on entry to DONE.
          cout_d  = dcarry;
          ovf_d   = (sa_q == sb_q) && (dsum[DIGIT-1] != sa_q);
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = key_ok ? StIdle : decoy_next(state_q, NUM_DECOY);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
endmodule
